// File: rtl/vbuf_writer_pkg.sv
// vbuf_writer_pkg: shared constants and types for the frame buffer writer
package vbuf_writer_pkg;
  localparam logic [5:0] VBUF_BASE_HI = 6'b10;
  localparam int H_ACTIVE = 1920;
  localparam int V_ACTIVE = 1080;
  localparam int FRAME_WORDS_1080P = H_ACTIVE * V_ACTIVE * 3 / 16;
  typedef enum logic {S_IDLE, S_BURST} state_t;
endpackage

// File: rtl/vbuf_word_fifo.sv
// vbuf_word_fifo: synchronous show-ahead word FIFO
module vbuf_word_fifo #(
  parameter int DWIDTH = 128,
  parameter int AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DWIDTH-1:0] din,
  output logic [DWIDTH-1:0] dout,
  output logic [AW:0]       count
);
  logic [DWIDTH-1:0] mem [2**AW];
  logic [AW-1:0] wp, rp;
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  always_ff @(posedge clk)
    if (!rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(push);
      rp <= rp + AW'(pop);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
endmodule

// File: rtl/vbuf_writer.sv
// vbuf_writer: packs 24b pixels into 128b words and bursts them into a DDR frame buffer
module vbuf_writer
  import vbuf_writer_pkg::*;
#(
  parameter int BURST = 16,
  parameter int FRAME_WORDS = FRAME_WORDS_1080P,
  parameter int FIFO_AW = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   bufid,
  input  logic [23:0]  px_data,
  input  logic         px_valid,
  output logic         px_ready,
  input  logic         px_sof,
  output logic [27:0]  vbuf_address,
  output logic [7:0]   vbuf_burstcount,
  output logic         vbuf_write,
  output logic [127:0] vbuf_writedata,
  output logic [15:0]  vbuf_byteenable,
  input  logic         vbuf_waitrequest,
  output logic         frame_done,
  output logic         sync_err,
  output logic         busy
);
  localparam int FRAME_PX = FRAME_WORDS * 16 / 3;
  localparam int PXW = $clog2(FRAME_PX);
  localparam logic [FIFO_AW:0] RDY_MAX = (FIFO_AW+1)'(2**FIFO_AW - 2);
  localparam logic [FIFO_AW:0] BURST_CNT = (FIFO_AW+1)'(BURST);
  localparam logic [18:0] LAST_OFF = 19'(FRAME_WORDS - BURST);
  state_t state;
  logic [FIFO_AW:0] cnt;
  logic [127:0] head, word;
  logic [119:0] pk;
  logic [143:0] nxt;
  logic [4:0] s;
  logic [3:0] pc;
  logic [PXW-1:0] pxc;
  logic [18:0] offset;
  logic [1:0] buf_q;
  logic [7:0] beat;
  logic acc, push, done, last;
  assign px_ready = rst & (cnt <= RDY_MAX);
  assign acc = px_valid & px_ready;
  assign s = {1'b0, pc} + 5'd3;
  assign nxt = {pk, px_data};
  // pending bytes are right-aligned; the completed word is the oldest 16 of them
  assign word = s[1:0] == 2'd0 ? nxt[127:0] : s[1:0] == 2'd1 ? nxt[135:8] : nxt[143:16];
  assign push = acc & s[4];
  assign done = vbuf_write & ~vbuf_waitrequest;
  assign last = done & (beat == 8'(BURST - 1));
  assign frame_done = last & (offset == LAST_OFF);
  assign vbuf_writedata = vbuf_write ? {head[63:0], head[127:64]} : '0;
  assign vbuf_byteenable = 16'hFFFF;
  assign busy = (cnt != '0) | (pc != '0) | (state == S_BURST);
  vbuf_word_fifo #(.DWIDTH(128), .AW(FIFO_AW)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(done), .din(word), .dout(head), .count(cnt)
  );
  always_ff @(posedge clk)
    if (!rst) begin
      pk <= '0;
      pc <= '0;
      pxc <= '0;
      sync_err <= 1'b0;
    end else if (acc) begin
      pk <= nxt[119:0];
      pc <= s[3:0];
      pxc <= pxc == PXW'(FRAME_PX - 1) ? '0 : pxc + 1'b1;
      if (px_sof && pxc != '0) sync_err <= 1'b1;
    end
  always_ff @(posedge clk)
    if (!rst) begin
      state <= S_IDLE;
      vbuf_write <= 1'b0;
      vbuf_address <= '0;
      vbuf_burstcount <= '0;
      offset <= '0;
      buf_q <= '0;
      beat <= '0;
    end else if (state == S_IDLE) begin
      if (cnt >= BURST_CNT) begin
        state <= S_BURST;
        vbuf_write <= 1'b1;
        beat <= '0;
        vbuf_burstcount <= 8'(BURST);
        vbuf_address <= {1'b0, VBUF_BASE_HI, (offset == '0 ? bufid : buf_q), 19'h0} + 28'(offset);
        if (offset == '0) buf_q <= bufid;
      end
    end else if (done) begin
      beat <= beat + 8'd1;
      if (last) begin
        vbuf_write <= 1'b0;
        state <= S_IDLE;
        offset <= frame_done ? '0 : offset + 19'(BURST);
      end
    end
endmodule
